// File: rtl/fft8_pkg.sv
// Shared types, twiddle table and helpers for the 8-point forward DIT FFT engine.
package fft8_pkg;

  typedef enum logic [1:0] {LOAD, COMPUTE, UNLOAD} state_e;

  // Q1.6 twiddles W8^t = exp(-j*2*pi*t/8), t = 0..3
  localparam logic signed [7:0] W_RE [4] = '{8'sd64, 8'sd45, 8'sd0, -8'sd45};
  localparam logic signed [7:0] W_IM [4] = '{8'sd0, -8'sd45, -8'sd64, -8'sd45};

  function automatic logic [2:0] bitrev3(input logic [2:0] n);
    return {n[0], n[1], n[2]};
  endfunction

  // Clamp v into the signed range of a w-bit word; caller narrows the result.
  function automatic logic signed [31:0] sat(input logic signed [31:0] v, input int w);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -hi - 32'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/fft8_butterfly.sv
// Combinational radix-2 DIT butterfly: top' = (a + W*b)/2, bot' = (a - W*b)/2, saturated.
module fft8_butterfly
  import fft8_pkg::*;
#(
  parameter int DW      = 8,
  parameter int TW_FRAC = 6
) (
  input  logic signed [DW-1:0] a_re,
  input  logic signed [DW-1:0] a_im,
  input  logic signed [DW-1:0] b_re,
  input  logic signed [DW-1:0] b_im,
  input  logic        [1:0]    tw_idx,
  output logic signed [DW-1:0] top_re,
  output logic signed [DW-1:0] top_im,
  output logic signed [DW-1:0] bot_re,
  output logic signed [DW-1:0] bot_im
);

  localparam logic signed [31:0] RND = 32'sd1 <<< (TW_FRAC - 1);

  logic signed [31:0] wr, wi, ar, ai, br, bi, pr, pi;

  always_comb begin
    wr = 32'(W_RE[tw_idx]);
    wi = 32'(W_IM[tw_idx]);
    ar = 32'(a_re);
    ai = 32'(a_im);
    br = 32'(b_re);
    bi = 32'(b_im);
    pr = (wr * br - wi * bi + RND) >>> TW_FRAC;
    pi = (wr * bi + wi * br + RND) >>> TW_FRAC;
    top_re = DW'(sat((ar + pr) >>> 1, DW));
    top_im = DW'(sat((ai + pi) >>> 1, DW));
    bot_re = DW'(sat((ar - pr) >>> 1, DW));
    bot_im = DW'(sat((ai - pi) >>> 1, DW));
  end

endmodule

// File: rtl/fft8_dit_engine.sv
// Forward 8-point radix-2 DIT FFT: serial load in bit-reversed order, in-place compute
// with one shared butterfly, natural-order streamed output scaled by 1/8.
module fft8_dit_engine
  import fft8_pkg::*;
#(
  parameter int DW      = 8,
  parameter int TW_FRAC = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_real,
  input  logic [DW-1:0] in_img,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_real,
  output logic [DW-1:0] out_img,
  output logic          out_last,
  output logic          busy
);

  state_e state_q, state_d;

  logic signed [DW-1:0] re_q [8];
  logic signed [DW-1:0] im_q [8];
  logic [2:0]           cnt_q;
  logic [2:0]           cnt_nx;
  logic [1:0]           bf_q;
  logic [1:0]           stage_q;
  logic                 out_valid_q, out_last_q;
  logic [DW-1:0]        out_re_q, out_im_q;

  logic                 in_fire, out_fire, last_bf;
  logic [2:0]           top_idx, bot_idx;
  logic [1:0]           tw_idx;
  logic signed [DW-1:0] top_re, top_im, bot_re, bot_im;

  assign in_ready  = (state_q == LOAD);
  assign busy      = (state_q != LOAD);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid_q && out_ready;
  assign last_bf   = (stage_q == 2'd2) && (bf_q == 2'd3);
  assign cnt_nx    = cnt_q + 3'd1;
  assign out_valid = out_valid_q;
  assign out_real  = out_re_q;
  assign out_img   = out_im_q;
  assign out_last  = out_last_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LOAD:    if (in_fire && cnt_q == 3'd7) state_d = COMPUTE;
      COMPUTE: if (last_bf) state_d = UNLOAD;
      UNLOAD:  if (out_fire && cnt_q == 3'd7) state_d = LOAD;
      default: state_d = LOAD;
    endcase
  end

  // Span h = 2^stage: top = (j/h)*2h + j%h, bot = top + h, twiddle = (j%h)*(4/h).
  always_comb begin
    top_idx = '0;
    bot_idx = '0;
    tw_idx  = '0;
    unique case (stage_q)
      2'd0: begin
        top_idx = {bf_q, 1'b0};
        bot_idx = {bf_q, 1'b1};
        tw_idx  = 2'd0;
      end
      2'd1: begin
        top_idx = {bf_q[1], 1'b0, bf_q[0]};
        bot_idx = {bf_q[1], 1'b1, bf_q[0]};
        tw_idx  = {bf_q[0], 1'b0};
      end
      default: begin
        top_idx = {1'b0, bf_q};
        bot_idx = {1'b1, bf_q};
        tw_idx  = bf_q;
      end
    endcase
  end

  fft8_butterfly #(
    .DW      (DW),
    .TW_FRAC (TW_FRAC)
  ) u_bfly (
    .a_re   (re_q[top_idx]),
    .a_im   (im_q[top_idx]),
    .b_re   (re_q[bot_idx]),
    .b_im   (im_q[bot_idx]),
    .tw_idx (tw_idx),
    .top_re (top_re),
    .top_im (top_im),
    .bot_re (bot_re),
    .bot_im (bot_im)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= LOAD;
      cnt_q       <= '0;
      bf_q        <= '0;
      stage_q     <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_re_q    <= '0;
      out_im_q    <= '0;
      for (int unsigned i = 0; i < 8; i++) begin
        re_q[i] <= '0;
        im_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      unique case (state_q)
        LOAD: begin
          if (in_fire) begin
            re_q[bitrev3(cnt_q)] <= in_real;
            im_q[bitrev3(cnt_q)] <= in_img;
            cnt_q                <= cnt_nx;
          end
        end
        COMPUTE: begin
          re_q[top_idx] <= top_re;
          im_q[top_idx] <= top_im;
          re_q[bot_idx] <= bot_re;
          im_q[bot_idx] <= bot_im;
          bf_q          <= bf_q + 2'd1;
          if (bf_q == 2'd3) stage_q <= last_bf ? 2'd0 : stage_q + 2'd1;
          // Bin 0 is final after the first stage-2 butterfly, so it can be
          // registered on the last compute cycle to meet the 13-cycle latency.
          if (last_bf) begin
            out_valid_q <= 1'b1;
            out_last_q  <= 1'b0;
            out_re_q    <= re_q[0];
            out_im_q    <= im_q[0];
            cnt_q       <= '0;
          end
        end
        UNLOAD: begin
          if (out_fire) begin
            if (cnt_q == 3'd7) begin
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              out_re_q    <= '0;
              out_im_q    <= '0;
              cnt_q       <= '0;
            end else begin
              out_re_q   <= re_q[cnt_nx];
              out_im_q   <= im_q[cnt_nx];
              out_last_q <= (cnt_nx == 3'd7);
              cnt_q      <= cnt_nx;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fft8_dit_engine.sv
// Scoreboard bench for fft8_dit_engine: frame-level FFT reference model feeds a queue,
// an independent monitor checks every presented bin, latency, stalls and handshakes.
module tb_fft8_dit_engine;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_real, in_img;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_real, out_img;
  logic          out_last;
  logic          busy;

  fft8_dit_engine #(
    .DW      (DW),
    .TW_FRAC (6)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_real   (in_real),
    .in_img    (in_img),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_real  (out_real),
    .out_img   (out_img),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int re;
    int im;
    bit last;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   bp_mode = 0;
  int   fr [8];
  int   fi [8];
  int   twr [4] = '{64, 45, 0, -45};
  int   twi [4] = '{0, -45, -64, -45};

  function automatic int clamp8(input int v);
    if (v > 127) return 127;
    if (v < -128) return -128;
    return v;
  endfunction

  // Frame-level reference: bit-reversed load, three in-place stages, 1/2 scaling per stage.
  task automatic model_frame();
    int ar [8];
    int ai [8];
    int h, top, bot, t, pr, pi, nr, ni;
    exp_t e;
    for (int n = 0; n < 8; n++) begin
      int r;
      r = ((n & 1) << 2) | (n & 2) | ((n >> 2) & 1);
      ar[r] = fr[n];
      ai[r] = fi[n];
    end
    for (int s = 0; s < 3; s++) begin
      h = 1 << s;
      for (int j = 0; j < 4; j++) begin
        top = (j / h) * 2 * h + (j % h);
        bot = top + h;
        t   = (j % h) * (4 / h);
        pr  = (twr[t] * ar[bot] - twi[t] * ai[bot] + 32) >>> 6;
        pi  = (twr[t] * ai[bot] + twi[t] * ar[bot] + 32) >>> 6;
        nr  = clamp8((ar[top] + pr) >>> 1);
        ni  = clamp8((ai[top] + pi) >>> 1);
        ar[bot] = clamp8((ar[top] - pr) >>> 1);
        ai[bot] = clamp8((ai[top] - pi) >>> 1);
        ar[top] = nr;
        ai[top] = ni;
      end
    end
    for (int k = 0; k < 8; k++) begin
      e.re = ar[k];
      e.im = ai[k];
      e.last = (k == 7);
      sb.push_back(e);
    end
  endtask

  task automatic push_const(input int r0, input int i0, input int rk, input int ik);
    exp_t e;
    for (int k = 0; k < 8; k++) begin
      e.re = (k == 0) ? r0 : rk;
      e.im = (k == 0) ? i0 : ik;
      e.last = (k == 7);
      sb.push_back(e);
    end
  endtask

  task automatic set_frame(input int r, input int i, input int pos);
    for (int n = 0; n < 8; n++) begin
      fr[n] = (pos < 0 || n == pos) ? r : 0;
      fi[n] = (pos < 0 || n == pos) ? i : 0;
    end
  endtask

  task automatic send_frame(input bit gaps);
    int wt;
    for (int n = 0; n < 8; n++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_real  = 8'(fr[n]);
      in_img   = 8'(fi[n]);
      wt = 0;
      while (!in_ready && wt < 200) begin
        @(posedge clk); #1;
        wt++;
      end
      if (wt >= 200) begin
        checks++;
        errors++;
        $display("FAIL in_ready_timeout beat %0d: in_ready=%0b required 1", n, in_ready);
        in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int wt;
    wt = 0;
    while (sb.size() != 0 && wt < 400) begin
      @(posedge clk); #1;
      wt++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d bins outstanding, required 0", sb.size());
      sb.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || out_last !== 1'b0 ||
        out_real !== 8'h00 || out_img !== 8'h00) begin
      errors++;
      $display("FAIL %s: valid=%0b ready=%0b busy=%0b last=%0b re=%0d im=%0d required 0 1 0 0 0 0",
               tag, out_valid, in_ready, busy, out_last, $signed(out_real), $signed(out_img));
    end
  endtask

  // Backpressure pattern generator
  initial begin
    int ph;
    ph = 0;
    out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (bp_mode)
        0:       out_ready = 1'b1;
        1:       begin out_ready = (ph % 3 == 0); ph++; end
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: compares each presented bin against the queue head, pops on handshake.
  initial begin
    int   neg, acc_neg, beats;
    bit   prev_valid, mid;
    exp_t e;
    neg = 0; acc_neg = -1000; beats = 0; prev_valid = 0; mid = 0;
    forever begin
      @(negedge clk);
      neg++;
      if (!rst_n) begin
        beats = 0; mid = 0; prev_valid = 0;
        continue;
      end
      if (in_valid && in_ready) begin
        if (beats == 7) acc_neg = neg;
        beats = (beats + 1) % 8;
      end
      if (mid) begin
        checks++;
        if (!out_valid) begin
          errors++;
          $display("FAIL no_bubble: out_valid=0 required 1 mid-frame");
        end
      end
      if (out_valid) begin
        checks++;
        if (in_ready !== 1'b0 || busy !== 1'b1) begin
          errors++;
          $display("FAIL ready_busy_in_unload: in_ready=%0b busy=%0b required 0 1", in_ready, busy);
        end
        if (!prev_valid) begin
          checks++;
          if (neg - acc_neg != 13) begin
            errors++;
            $display("FAIL latency: %0d cycles required 13", neg - acc_neg);
          end
        end
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_bin: re=%0d im=%0d with empty scoreboard", $signed(out_real), $signed(out_img));
        end else begin
          e = sb[0];
          if (int'($signed(out_real)) != e.re || int'($signed(out_img)) != e.im || out_last != e.last) begin
            errors++;
            $display("FAIL bin (8 - %0d left): got (%0d,%0d) last=%0b required (%0d,%0d) last=%0b",
                     sb.size(), $signed(out_real), $signed(out_img), out_last, e.re, e.im, e.last);
          end
          if (out_ready) void'(sb.pop_front());
        end
      end
      prev_valid = out_valid;
      mid = out_valid && !(out_ready && out_last);
    end
  end

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_real = '0;
    in_img = '0;
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset_state");
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_idle("after_release");

    bp_mode = 0;
    set_frame(64, 0, 0);   push_const(8, 0, 8, 0);  send_frame(0); drain();
    set_frame(16, 0, -1);  push_const(16, 0, 0, 0); send_frame(0); drain();
    set_frame(64, 0, 1);   model_frame();           send_frame(0); drain();

    bp_mode = 1;
    set_frame(64, 0, 0);   push_const(8, 0, 8, 0);  send_frame(0); drain();

    bp_mode = 0;
    set_frame(127, 127, -1);   model_frame(); send_frame(0);
    set_frame(-128, -128, -1); model_frame(); send_frame(0);
    drain();

    // Reset during compute cycle 5
    set_frame(64, 0, 1); model_frame(); send_frame(0);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    sb.delete();
    #1;
    check_idle("async_reset_mid_compute");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_idle("after_mid_reset");
    set_frame(16, 0, -1); push_const(16, 0, 0, 0); send_frame(0); drain();

    for (int f = 0; f < 12; f++) begin
      bp_mode = $urandom_range(0, 2);
      for (int n = 0; n < 8; n++) begin
        fr[n] = int'($urandom_range(0, 255)) - 128;
        fi[n] = int'($urandom_range(0, 255)) - 128;
      end
      model_frame();
      send_frame(1);
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
